// File: rtl/if_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-bus request/grant/response bundle; master is the fetch unit, slave the memory.
interface if_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_gnt_i,
        input  ibus_rvalid_i,
        input  ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_gnt_i,
        output ibus_rvalid_i,
        output ibus_rdata_i
    );
endinterface

// File: rtl/if_fetch_buf.sv
// One-entry instruction/address holding register; contents visible the cycle after load.
// Consume clears it unless a load lands in the same cycle; flush beats load beats consume.
module if_fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_addr,
    input  logic        i_consume,
    input  logic        i_flush,
    output logic        o_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_addr
);
    logic        r_vld;
    logic [31:0] r_inst;
    logic [31:0] r_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld  <= 1'b0;
            r_inst <= 32'h0;
            r_addr <= 32'h0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_inst <= i_inst;
            r_addr <= i_addr;
        end else if (i_consume && r_vld) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld  = r_vld;
    assign o_inst = r_inst;
    assign o_addr = r_addr;
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding ibus request feeding a 1-entry buffer; data shows 1 cycle after rvalid.
// hold_flag_i stalls new requests until the buffer drains; IF_FETCH_MISALIGN_CHK_EN traps misaligned jumps.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              hold_flag_i,
    if_fetch_if.master        ibus,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_addr_o,
    output logic              fetch_err_o
);
    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_req;
    logic         r_discard;
    logic         r_err;

    logic         w_buf_vld;
    logic [31:0]  w_buf_inst;
    logic [31:0]  w_buf_addr;
    logic         w_buf_free;
    logic         w_jump;
    logic         w_misalign;
    logic [31:0]  w_jump_tgt;
    logic         w_load;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    assign w_misalign = jump_en_i && (jump_addr_i[1:0] != 2'b00);
    assign w_jump_tgt = jump_addr_i;
`else
    assign w_misalign = 1'b0;
    assign w_jump_tgt = jump_addr_i & 32'hFFFF_FFFC;
`endif

    // Once trapped, redirects are ignored until reset.
    assign w_jump     = jump_en_i && (r_state != ST_ERR);
    assign w_buf_free = !w_buf_vld || !hold_flag_i;
    assign w_load     = (r_state == ST_WAIT) && ibus.ibus_rvalid_i && !r_discard && !jump_en_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_jump && w_misalign) begin
            r_state   <= ST_ERR;
            r_pc      <= w_jump_tgt;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
            r_err     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_jump) begin
                        r_pc    <= w_jump_tgt;
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end else if (w_buf_free) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_jump) begin
                        r_pc <= w_jump_tgt;
                        // A grant coinciding with the jump still owes us a response to swallow.
                        if (ibus.ibus_gnt_i) begin
                            r_state   <= ST_WAIT;
                            r_req     <= 1'b0;
                            r_discard <= 1'b1;
                        end
                    end else if (ibus.ibus_gnt_i) begin
                        r_pc    <= pc_next(r_pc);
                        r_state <= ST_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_jump) begin
                        r_pc <= w_jump_tgt;
                        if (ibus.ibus_rvalid_i) begin
                            r_state   <= ST_REQ;
                            r_req     <= 1'b1;
                            r_discard <= 1'b0;
                        end else begin
                            r_discard <= 1'b1;
                        end
                    end else if (ibus.ibus_rvalid_i) begin
                        r_discard <= 1'b0;
                        if (r_discard) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ERR;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    if_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_inst    (ibus.ibus_rdata_i),
        .i_addr    (r_pc - 32'd4),
        .i_consume (!hold_flag_i),
        .i_flush   (w_jump),
        .o_vld     (w_buf_vld),
        .o_inst    (w_buf_inst),
        .o_addr    (w_buf_addr)
    );

    assign ibus.ibus_req_o  = r_req;
    assign ibus.ibus_addr_o = r_pc;
    assign inst_o           = w_buf_vld ? w_buf_inst : INST_NOP;
    assign inst_addr_o      = w_buf_vld ? w_buf_addr : 32'h0;
    assign fetch_err_o      = r_err;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: hand-driven ibus handshakes with fixed expected addresses and data.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        fetch_err;
    int          n_chk = 0;
    int          n_err = 0;

    if_fetch_if bus ();

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .hold_flag_i (hold),
        .ibus        (bus.master),
        .inst_o      (inst),
        .inst_addr_o (inst_addr),
        .fetch_err_o (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.ibus_req_o === 1'b1) break;
            step();
        end
        chk({tag, "_req_seen"}, {31'h0, bus.ibus_req_o}, 32'h1);
    endtask

    // One full fetch: request at exp_addr, grant in the request cycle, data the next cycle.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        wait_req(tag);
        chk({tag, "_addr"}, bus.ibus_addr_o, exp_addr);
        bus.ibus_gnt_i = 1'b1;
        step();
        bus.ibus_gnt_i = 1'b0;
        chk({tag, "_no_req_in_wait"}, {31'h0, bus.ibus_req_o}, 32'h0);
        bus.ibus_rvalid_i = 1'b1;
        bus.ibus_rdata_i  = data;
        step();
        bus.ibus_rvalid_i = 1'b0;
        chk({tag, "_inst"}, inst, data);
        chk({tag, "_inst_addr"}, inst_addr, exp_addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b0;
        jump_en           = 1'b0;
        jump_addr         = 32'h0;
        hold              = 1'b0;
        bus.ibus_gnt_i    = 1'b0;
        bus.ibus_rvalid_i = 1'b0;
        bus.ibus_rdata_i  = 32'h0;
        step();
        step();
        chk("rst_req", {31'h0, bus.ibus_req_o}, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        rst = 1'b1;

        // Sequential fetch 0, 4, 8
        serve("seq0", 32'h0, 32'hAAAA_0000);
        serve("seq4", 32'h4, 32'hAAAA_0004);
        serve("seq8", 32'h8, 32'hAAAA_0008);

        // Hold with buffer at 8: contents frozen, no new request
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_inst_addr", inst_addr, 32'h8);
            chk("hold_inst", inst, 32'hAAAA_0008);
            chk("hold_no_req", {31'h0, bus.ibus_req_o}, 32'h0);
        end
        hold = 1'b0;
        serve("resume12", 32'hC, 32'hAAAA_000C);

        // Jump while waiting for response
        wait_req("wj");
        chk("wj_addr16", bus.ibus_addr_o, 32'h10);
        bus.ibus_gnt_i = 1'b1;
        step();
        bus.ibus_gnt_i = 1'b0;
        jump_en   = 1'b1;
        jump_addr = 32'h100;
        step();
        jump_en = 1'b0;
        chk("wj_flushed", inst, 32'h0000_0013);
        chk("wj_no_req", {31'h0, bus.ibus_req_o}, 32'h0);
        bus.ibus_rvalid_i = 1'b1;
        bus.ibus_rdata_i  = 32'hDEAD_0010;
        step();
        bus.ibus_rvalid_i = 1'b0;
        chk("wj_dropped", inst, 32'h0000_0013);
        chk("wj_req", {31'h0, bus.ibus_req_o}, 32'h1);
        serve("wj_tgt", 32'h100, 32'hBBBB_0100);

        // Jump in the same cycle as the grant at address 4
        rst = 1'b0;
        step();
        rst = 1'b1;
        serve("gj0", 32'h0, 32'hCCCC_0000);
        wait_req("gj");
        chk("gj_addr4", bus.ibus_addr_o, 32'h4);
        bus.ibus_gnt_i = 1'b1;
        jump_en        = 1'b1;
        jump_addr      = 32'h100;
        step();
        bus.ibus_gnt_i = 1'b0;
        jump_en        = 1'b0;
        chk("gj_no_req", {31'h0, bus.ibus_req_o}, 32'h0);
        bus.ibus_rvalid_i = 1'b1;
        bus.ibus_rdata_i  = 32'hBAD0_0004;
        step();
        bus.ibus_rvalid_i = 1'b0;
        chk("gj_dropped", inst, 32'h0000_0013);
        serve("gj_tgt", 32'h100, 32'hCCCC_0100);

        // Reset while a response is outstanding, then a stray rvalid
        wait_req("rw");
        chk("rw_addr", bus.ibus_addr_o, 32'h104);
        bus.ibus_gnt_i = 1'b1;
        step();
        bus.ibus_gnt_i = 1'b0;
        rst = 1'b0;
        step();
        chk("rw_inst", inst, 32'h0000_0013);
        chk("rw_inst_addr", inst_addr, 32'h0);
        chk("rw_req", {31'h0, bus.ibus_req_o}, 32'h0);
        rst               = 1'b1;
        bus.ibus_rvalid_i = 1'b1;
        bus.ibus_rdata_i  = 32'h5157_AB0F;
        step();
        bus.ibus_rvalid_i = 1'b0;
        chk("stray_inst", inst, 32'h0000_0013);
        chk("stray_inst_addr", inst_addr, 32'h0);
        serve("rw_restart", 32'h0, 32'hDDDD_0000);

        // PC wraps modulo 2^32
        jump_en   = 1'b1;
        jump_addr = 32'hFFFF_FFFC;
        step();
        jump_en = 1'b0;
        serve("wrap_top", 32'hFFFF_FFFC, 32'hEEEE_FFFC);
        wait_req("wrap");
        chk("wrap_zero", bus.ibus_addr_o, 32'h0);

        // Misaligned redirect while a request is pending without grant
        jump_en   = 1'b1;
        jump_addr = 32'h102;
        step();
        jump_en = 1'b0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            chk("mis_err", {31'h0, fetch_err}, 32'h1);
            chk("mis_no_req", {31'h0, bus.ibus_req_o}, 32'h0);
            chk("mis_inst", inst, 32'h0000_0013);
            step();
        end
`else
        chk("mis_err", {31'h0, fetch_err}, 32'h0);
        chk("mis_req", {31'h0, bus.ibus_req_o}, 32'h1);
        chk("mis_addr", bus.ibus_addr_o, 32'h100);
        serve("mis_tgt", 32'h100, 32'hFFFF_0100);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
